// File: rtl/seg7_pkg.sv
// seg7_pkg: hex glyph table, nibble-to-segment helper and blank pattern for the display driver
package seg7_pkg;
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
    return GLYPHS[nib];
  endfunction
endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: combinational hex nibble to active-high segments {g..a}
//  i_nib  nibble to decode
//  o_seg  segment pattern, bit0 = a
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = hex_to_seg7(i_nib);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed N-digit seven-segment driver with double-buffered loads
//  clk/rst_n         clock, async active-low reset
//  enable            scan on; off blanks all digits and clears scan state
//  load/value/dp_in  capture strobe and data into the shadow buffer
//  seg/dp_out/an     registered display pins (polarity set by parameters)
//  pending           shadow holds a load not yet displayed
//  frame_tick        one-cycle pulse after each frame boundary
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit LZ_SUPPRESS    = 1'b1,
  parameter bit ACTIVE_LOW_SEG = 1'b0,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame_tick
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW_SEG}};
  localparam logic [DIGITS-1:0] AN_POL = {DIGITS{ACTIVE_LOW_AN}};
  logic [PW-1:0] r_presc;
  logic [IW-1:0] r_idx;
  logic [DIGITS-1:0][3:0] r_shadow, r_active;
  logic [DIGITS-1:0] r_shadow_dp, r_active_dp, r_an, w_lz;
  logic [6:0] r_seg, w_glyph;
  logic r_dp, r_pending, r_frame_tick;
  logic w_tc, w_wrap, w_boundary, w_swap, w_blank;
  logic [3:0] w_nib;
  assign w_tc = r_presc == PW'(SCAN_DIV - 1);
  assign w_wrap = r_idx == IW'(DIGITS - 1);
  assign w_boundary = enable && w_tc && w_wrap;
  // shadow moves to active only at a frame boundary or while dark, so a frame never tears
  assign w_swap = r_pending && (w_boundary || !enable);
  assign w_nib = r_active[r_idx];
  // w_lz[i]: this digit and every digit above it are zero; digit 0 is never blanked
  for (genvar i = 0; i < DIGITS; i++) begin : g_lz
    assign w_lz[i] = (i != 0) && (r_active[DIGITS-1:i] == '0);
  end
  assign w_blank = LZ_SUPPRESS && w_lz[r_idx];
  seg7_glyph u_glyph (.i_nib(w_nib), .o_seg(w_glyph));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_shadow_dp  <= '0;
      r_active     <= '0;
      r_active_dp  <= '0;
      r_pending    <= 1'b0;
      r_frame_tick <= 1'b0;
      r_an         <= AN_POL;
      r_seg        <= SEG_POL;
      r_dp         <= ACTIVE_LOW_SEG;
    end else begin
      r_frame_tick <= w_boundary;
      if (load) begin
        r_shadow    <= value;
        r_shadow_dp <= dp_in;
      end
      if (w_swap) begin
        r_active    <= r_shadow;
        r_active_dp <= r_shadow_dp;
      end
      r_pending <= load || (r_pending && !w_swap);
      if (!enable) begin
        r_presc <= '0;
        r_idx   <= '0;
        r_an    <= AN_POL;
        r_seg   <= SEG_POL;
        r_dp    <= ACTIVE_LOW_SEG;
      end else begin
        r_presc <= w_tc ? '0 : r_presc + 1'b1;
        if (w_tc) r_idx <= w_wrap ? '0 : r_idx + 1'b1;
        // all digits dark on the terminal-count cycle so the next digit never ghosts
        r_an  <= (w_tc ? '0 : DIGITS'(1) << r_idx) ^ AN_POL;
        r_seg <= (w_blank ? SEG_OFF : w_glyph) ^ SEG_POL;
        r_dp  <= r_active_dp[r_idx] ^ ACTIVE_LOW_SEG;
      end
    end
  assign seg        = r_seg;
  assign dp_out     = r_dp;
  assign an         = r_an;
  assign pending    = r_pending;
  assign frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed self-checking bench for seg7_scan_driver (4 digits, 4-cycle slots)
module tb_seg7_scan_driver;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dp_in = '0;
  logic [6:0] seg;
  logic dp_out, pending, frame_tick;
  logic [3:0] an;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .seg(seg), .dp_out(dp_out), .an(an), .pending(pending), .frame_tick(frame_tick)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_load(input logic [15:0] v);
    value = v;
    load = 1'b1;
    step;
    load = 1'b0;
  endtask
  task automatic wait_boundary;
    int n;
    n = 0;
    do begin
      step;
      n++;
    end while (!frame_tick && n < 64);
    chk("boundary_seen", 32'(frame_tick), 32'd1);
  endtask
  task automatic check_frame(input logic [3:0][6:0] exp);
    logic [3:0] e;
    for (int d = 0; d < 4; d++) begin
      e = ~(4'b0001 << d);
      for (int c = 0; c < 3; c++) begin
        step;
        if (d == 0 && c == 0) chk("tick_one_cycle", 32'(frame_tick), 32'd0);
        chk("an_lit", 32'(an), 32'(e));
        chk("seg_lit", 32'(seg), 32'(exp[d]));
      end
      step;
      chk("an_guard", 32'(an), 32'hF);
    end
  endtask
  initial begin
    #12;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h00);
    chk("rst_dp", 32'(dp_out), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    do_load(16'h1234);
    chk("first_pending", 32'(pending), 32'd1);
    chk("first_an", 32'(an), 32'hE);
    chk("first_seg", 32'(seg), 32'h3F);
    wait_boundary;
    chk("applied_pending", 32'(pending), 32'd0);
    check_frame({7'h06, 7'h5B, 7'h4F, 7'h66});
    do_load(16'h0050);
    wait_boundary;
    check_frame({7'h00, 7'h00, 7'h6D, 7'h3F});
    do_load(16'h0000);
    wait_boundary;
    check_frame({7'h00, 7'h00, 7'h00, 7'h3F});
    do_load(16'h1234);
    wait_boundary;
    check_frame({7'h06, 7'h5B, 7'h4F, 7'h66});
    repeat (8) step;
    do_load(16'hABCD);
    chk("midframe_pending", 32'(pending), 32'd1);
    chk("midframe_an", 32'(an), 32'hB);
    chk("midframe_old_seg", 32'(seg), 32'h5B);
    wait_boundary;
    chk("abcd_pending", 32'(pending), 32'd0);
    check_frame({7'h77, 7'h7C, 7'h39, 7'h5E});
    do_load(16'h1111);
    do_load(16'h2222);
    wait_boundary;
    check_frame({7'h5B, 7'h5B, 7'h5B, 7'h5B});
    do_load(16'h5555);
    step;
    chk("pre_reset_pending", 32'(pending), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'hF);
    chk("async_seg", 32'(seg), 32'h00);
    chk("async_pending", 32'(pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step;
    chk("post_reset_an", 32'(an), 32'hE);
    chk("post_reset_seg", 32'(seg), 32'h3F);
    repeat (4) step;
    enable = 1'b0;
    step;
    chk("dis_an", 32'(an), 32'hF);
    chk("dis_seg", 32'(seg), 32'h00);
    chk("dis_tick", 32'(frame_tick), 32'd0);
    do_load(16'h00F0);
    chk("dis_load_pending", 32'(pending), 32'd1);
    step;
    chk("dis_pending_clear", 32'(pending), 32'd0);
    enable = 1'b1;
    step;
    chk("reen_an", 32'(an), 32'hE);
    chk("reen_seg", 32'(seg), 32'h3F);
    repeat (2) step;
    step;
    chk("reen_guard", 32'(an), 32'hF);
    step;
    chk("reen_d1_an", 32'(an), 32'hD);
    chk("reen_d1_seg", 32'(seg), 32'h71);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
